xnormaj_popcount_threshold: RTL

Downstream consumer of the registered XNOR-majority stage. It collects a stream of single majority bits, one per accepted beat, into groups of N bits; each group forms one neuron. For each group it counts the ones, compares the count against a per-neuron threshold, and emits a binarised activation together with the raw count. A valid/ready handshake sits on both sides, so the block can feed the next layer's activation buffer under backpressure.

---
 rtl/xnormaj_popcount_threshold_if.sv | 27 ++
 rtl/xnormaj_popcount_threshold.sv | 86 ++++++++
 2 files changed

// File: rtl/xnormaj_popcount_threshold_if.sv
// Handshake bundle between the majority-bit producer, the popcount/threshold
// block and the downstream activation buffer.
interface xnormaj_popcount_threshold_if #(
    parameter int CW = 5
);
    logic          m_in;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] thr;
    logic          out_valid;
    logic          out_ready;
    logic          out_bit;
    logic [CW-1:0] out_count;

    // Valid/ready on both sides: a beat transfers on a rising clk edge where
    // valid && ready; the sender holds data stable while valid is high and
    // ready is low, and ready may depend combinationally on the other side.
    modport master (
        output m_in, m_valid, thr, out_ready,
        input  m_ready, out_valid, out_bit, out_count
    );

    modport slave (
        input  m_in, m_valid, thr, out_ready,
        output m_ready, out_valid, out_bit, out_count
    );
endinterface

// File: rtl/xnormaj_popcount_threshold.sv
// Groups N majority bits into one neuron, counts the ones and binarises the
// count against a threshold latched on the group's first bit.
module xnormaj_popcount_threshold #(
    parameter int N  = 16,
    parameter int CW = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    xnormaj_popcount_threshold_if.slave   bus,
    output logic                          dbg_state_o
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] acc_q;
    logic [CW-1:0] thr_q;
    logic          out_valid_q;
    logic          out_bit_q;
    logic [CW-1:0] out_count_q;

    logic          accept;
    logic          drain;
    logic          first_bit;
    logic [CW-1:0] acc_d;
    logic [CW-1:0] thr_d;

    // In OUT, ready passes through so the next group can start as the result drains.
    assign bus.m_ready = (state_q == ACC) || bus.out_ready;
    assign accept      = bus.m_valid && bus.m_ready;
    assign drain       = out_valid_q && bus.out_ready;
    assign first_bit   = (idx_q == '0);

    // With N==1 the first bit is also the last, so the live threshold applies.
    assign acc_d = first_bit ? CW'(bus.m_in) : acc_q + CW'(bus.m_in);
    assign thr_d = first_bit ? bus.thr : thr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            idx_q       <= '0;
            acc_q       <= '0;
            thr_q       <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_count_q <= '0;
        end else if (clear) begin
            state_q     <= ACC;
            idx_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (drain) begin
                out_valid_q <= 1'b0;
                state_q     <= ACC;
            end
            if (accept) begin
                acc_q <= acc_d;
                if (first_bit) begin
                    thr_q <= bus.thr;
                end
                if (idx_q == LAST_IDX) begin
                    idx_q       <= '0;
                    out_count_q <= acc_d;
                    out_bit_q   <= (acc_d >= thr_d);
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_count = out_count_q;
    assign dbg_state_o   = state_q;
endmodule
